// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16x16 shift-add multiplier producing the low 16 bits
// of the product (identical for signed and unsigned operands). All additions
// go through the 16-bit ripple adder adder16, so carries out of bit 15 are lost
// and the product wraps mod 2^16.
//
// Optional feature: define MUL16_EARLY_EXIT_EN to finish the run as soon as no
// set multiplier bits remain. Without it every operation takes 16 RUN cycles.

// 16-bit ripple-carry adder with no carry-in and no carry-out.
module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic [15:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_sum
        assign sum[i] = a[i] ^ b[i] ^ carry_s[i];
    end

    // The carry out of bit 15 would have nowhere to go, so the chain stops at bit 14.
    for (genvar i = 0; i < 15; i++) begin : g_carry
        assign carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
    end

endmodule

module mul16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [15:0] mcand_r;
    logic [15:0] mplier_r;
    logic [15:0] acc_r;
    logic [3:0]  count_r;
    logic [15:0] result_r;
    logic        busy_r;
    logic        done_r;

    logic [15:0] sum_s;
    logic [15:0] acc_next_s;
    logic        accept_s;
    logic        last_iter_s;

    // The only adder in the block: running partial product plus shifted multiplicand.
    adder16 u_adder16 (
        .a   (acc_r),
        .b   (mcand_r),
        .sum (sum_s)
    );

    assign acc_next_s = mplier_r[0] ? sum_s : acc_r;

    // A start is honoured only when no operation is in flight (IDLE or DONE).
    assign accept_s = start & ~busy_r;

`ifdef MUL16_EARLY_EXIT_EN
    // Stop once the bits still to be consumed after this step are all zero.
    assign last_iter_s = (count_r == 4'd15) || (mplier_r[15:1] == 15'd0);
`else
    assign last_iter_s = (count_r == 4'd15);
`endif

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus busy/done flags registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand capture, shift-add iteration and result latch on the final step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r  <= 16'h0000;
            mplier_r <= 16'h0000;
            acc_r    <= 16'h0000;
            count_r  <= 4'd0;
            result_r <= 16'h0000;
        end else if (accept_s) begin
            mcand_r  <= in1;
            mplier_r <= in2;
            acc_r    <= 16'h0000;
            count_r  <= 4'd0;
        end else if (state_r == RUN) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[14:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[15:1]};
            count_r  <= count_r + 4'd1;
            if (last_iter_s) begin
                result_r <= acc_next_s;
            end
        end
    end

    // Outputs come straight from flops; the partial product never leaves the block.
    assign busy = busy_r;
    assign done = done_r;
    assign out  = result_r;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: a table of directed multiplies (product,
// latency and done width) plus hand-written back-to-back, ignored-start and
// mid-run reset sequences. Works for both builds of MUL16_EARLY_EXIT_EN.
`timescale 1ns/1ps

module tb_mul16_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [12];

    mul16_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected number of RUN cycles for a given multiplier.
    function automatic int exp_lat(input logic [15:0] b);
`ifdef MUL16_EARLY_EXIT_EN
        int hi;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) hi = i;
        end
        return hi + 1;
`else
        return 16;
`endif
    endfunction

    // Sample at negedges until done; count cycles with busy high. Bounded.
    task automatic wait_done(input string name, output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) lat++;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within 40 cycles", name);
        end
    endtask

    // One complete operation: pulse start, wait, check product/latency/pulse width.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
        int lat;
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1   = 16'hDEAD;
        in2   = 16'hBEEF;
        lat   = busy ? 1 : 0;
        if (!done) begin
            int more;
            wait_done("vec", more);
            lat += more;
        end
        check($sformatf("out_%h_x_%h", a, b), {16'h0, out}, {16'h0, p});
        check($sformatf("lat_%h_x_%h", a, b), lat, exp_lat(b));
        check("busy_in_done", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("done_one_cycle", {31'h0, done}, 32'h0);
        check("out_holds", {16'h0, out}, {16'h0, p});
    endtask

    initial begin
        int lat;
        int k;
        bit held;
        n_checks = 0;
        n_fail   = 0;
        start    = 1'b0;
        in1      = 16'h0000;
        in2      = 16'h0000;
        reset    = 1'b1;

        vecs[0]  = '{16'h0003, 16'h0005, 16'h000F};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[2]  = '{16'hFFFD, 16'h0005, 16'hFFF1};
        vecs[3]  = '{16'h0100, 16'h0100, 16'h0000};
        vecs[4]  = '{16'h1234, 16'h0010, 16'h2340};
        vecs[5]  = '{16'hBEEF, 16'h0001, 16'hBEEF};
        vecs[6]  = '{16'h1234, 16'h0000, 16'h0000};
        vecs[7]  = '{16'h0007, 16'h8000, 16'h8000};
        vecs[8]  = '{16'h00FF, 16'h0101, 16'hFFFF};
        vecs[9]  = '{16'h1111, 16'h000F, 16'hFFFF};
        vecs[10] = '{16'hABCD, 16'h0003, 16'h0367};
        vecs[11] = '{16'h0002, 16'h0003, 16'h0006};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_out", {16'h0, out}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // Table-driven products.
        for (int i = 0; i < 12; i++) begin
            do_mul(vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Back-to-back: hold start through done.
        @(negedge clk);
        in1   = 16'h1234;
        in2   = 16'h0010;
        start = 1'b1;
        @(negedge clk);
        in1   = 16'h0002;
        in2   = 16'h0007;
        wait_done("b2b_first", lat);
        check("b2b_first_out", {16'h0, out}, 32'h2340);
        @(negedge clk);
        start = 1'b0;
        in1   = 16'h0000;
        in2   = 16'h0000;
        check("b2b_no_idle", {31'h0, busy}, 32'h1);
        held = 1'b1;
        lat  = 1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (out !== 16'h2340) held = 1'b0;
            @(negedge clk);
            if (!done && busy) lat++;
        end
        check("b2b_out_held", {31'h0, held}, 32'h1);
        check("b2b_second_done", {31'h0, done}, 32'h1);
        check("b2b_second_out", {16'h0, out}, 32'h000E);
        check("b2b_second_lat", lat, exp_lat(16'h0007));

        // Start pulsed mid-run is ignored.
`ifdef MUL16_EARLY_EXIT_EN
        k = 2;
`else
        k = 5;
`endif
        @(negedge clk);
        in1   = 16'h0003;
        in2   = 16'h0005;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        for (int c = 1; c < k; c++) begin
            @(negedge clk);
            if (busy && !done) lat++;
        end
        in1   = 16'hAAAA;
        in2   = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy && !done) lat++;
        begin
            int more;
            wait_done("ign", more);
            lat += more;
        end
        check("ign_lat", lat, exp_lat(16'h0005));
        check("ign_out", {16'h0, out}, 32'h000F);
        @(negedge clk);
        check("ign_no_restart", {31'h0, busy}, 32'h0);

        // Reset asserted mid-run.
        @(negedge clk);
        in1   = 16'h0003;
        in2   = 16'h8005;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        check("arst_out", {16'h0, out}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        held  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) held = 1'b1;
        end
        check("arst_no_done", {31'h0, held}, 32'h0);
        do_mul(16'h0002, 16'h0003, 16'h0006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
